// File: rtl/pipe_ctrl_if.sv
// rtl/pipe_ctrl_if.sv - pipeline controller signal bundle (stall requests, trap/branch inputs, control outputs)
interface pipe_ctrl_if;
    logic        stallreq_if_i;
    logic        stallreq_id_i;
    logic        stallreq_ex_i;
    logic        stallreq_mem_i;
    logic        lsu_busy_i;
    logic [31:0] exception_i;
    logic        mret_i;
    logic [31:0] mem_pc_i;
    logic [31:0] mtvec_i;
    logic [31:0] mepc_i;
    logic        branch_i;
    logic [31:0] branch_target_i;
    logic [5:0]  stall_o;
    logic        flush_o;
    logic        redirect_valid_o;
    logic [31:0] redirect_pc_o;
    logic        trap_taken_o;
    logic [31:0] trap_epc_o;
    logic [4:0]  trap_cause_o;

    modport master (
        output stallreq_if_i, stallreq_id_i, stallreq_ex_i, stallreq_mem_i, lsu_busy_i,
               exception_i, mret_i, mem_pc_i, mtvec_i, mepc_i, branch_i, branch_target_i,
        input  stall_o, flush_o, redirect_valid_o, redirect_pc_o,
               trap_taken_o, trap_epc_o, trap_cause_o
    );

    modport slave (
        input  stallreq_if_i, stallreq_id_i, stallreq_ex_i, stallreq_mem_i, lsu_busy_i,
               exception_i, mret_i, mem_pc_i, mtvec_i, mepc_i, branch_i, branch_target_i,
        output stall_o, flush_o, redirect_valid_o, redirect_pc_o,
               trap_taken_o, trap_epc_o, trap_cause_o
    );
endinterface

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - stall merge, trap/mret drain-flush-redirect sequencing and branch redirect queueing
module pipe_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic       clk_i,
    input  logic       n_rst_i,
    pipe_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, DRAIN = 2'd1, FLUSH = 2'd2} state_e;

    state_e      state_q, state_d;
    logic        kind_mret_q;
    logic [31:0] epc_q;
    logic [4:0]  cause_q;
    logic        pend_q, pend_d;
    logic [31:0] pend_pc_q, pend_pc_d;
    logic        flush_q, flush_d;
    logic        rv_q, rv_d;
    logic [31:0] rpc_q, rpc_d;
    logic        tt_q, tt_d;
    logic [31:0] tepc_q, tepc_d;
    logic [4:0]  tcause_q, tcause_d;

    logic        exc_any, trap_req, enter_flush, use_mret;
    logic [31:0] use_epc;
    logic [4:0]  use_cause, exc_cause;
    logic [5:0]  stall;

    always_comb begin
        exc_cause = '0;
        for (int i = 31; i >= 0; i--) begin
            if (bus.exception_i[i]) exc_cause = 5'(i);
        end
    end

    assign exc_any  = |bus.exception_i;
    assign trap_req = exc_any | bus.mret_i;

    always_ff @(posedge clk_i) begin
        if (!n_rst_i) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (trap_req) state_d = bus.lsu_busy_i ? DRAIN : FLUSH;
            DRAIN:   if (!bus.lsu_busy_i) state_d = FLUSH;
            FLUSH:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FLUSH never follows itself, so a next state of FLUSH always marks entry.
    assign enter_flush = (state_d == FLUSH);
    assign use_mret    = (state_q == IDLE) ? !exc_any        : kind_mret_q;
    assign use_epc     = (state_q == IDLE) ? bus.mem_pc_i    : epc_q;
    assign use_cause   = (state_q == IDLE) ? exc_cause       : cause_q;

    always_comb begin
        stall     = '0;
        flush_d   = 1'b0;
        rv_d      = 1'b0;
        rpc_d     = rpc_q;
        tt_d      = 1'b0;
        tepc_d    = tepc_q;
        tcause_d  = tcause_q;
        pend_d    = pend_q;
        pend_pc_d = pend_pc_q;
        case (state_q)
            IDLE: begin
                if (trap_req)                stall = 6'b111111;
                else if (bus.stallreq_mem_i) stall = 6'b011111;
                else if (bus.stallreq_ex_i)  stall = 6'b001111;
                else if (bus.stallreq_id_i)  stall = 6'b000111;
                else if (bus.stallreq_if_i)  stall = 6'b000011;
            end
            DRAIN:   stall = 6'b111111;
            default: stall = '0;
        endcase
        if (enter_flush) begin
            flush_d = 1'b1;
            rv_d    = 1'b1;
            pend_d  = 1'b0;
            rpc_d   = use_mret ? bus.mepc_i : (bus.mtvec_i & ~32'h3);
            if (!use_mret) begin
                tt_d     = 1'b1;
                tepc_d   = use_epc;
                tcause_d = use_cause;
            end
        end else if (state_q != FLUSH) begin
            // The ex-stage instruction is discarded during FLUSH, so its branch is ignored there.
            if (!stall[3] && (pend_q || bus.branch_i)) begin
                rv_d   = 1'b1;
                rpc_d  = pend_q ? pend_pc_q : bus.branch_target_i;
                pend_d = 1'b0;
            end else if (stall[3] && bus.branch_i && !pend_q) begin
                pend_d    = 1'b1;
                pend_pc_d = bus.branch_target_i;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!n_rst_i) begin
            kind_mret_q <= 1'b0;
            epc_q       <= '0;
            cause_q     <= '0;
            pend_q      <= 1'b0;
            pend_pc_q   <= '0;
            flush_q     <= 1'b0;
            rv_q        <= 1'b1;
            rpc_q       <= RESET_PC;
            tt_q        <= 1'b0;
            tepc_q      <= '0;
            tcause_q    <= '0;
        end else begin
            if (state_q == IDLE && trap_req) begin
                kind_mret_q <= !exc_any;
                epc_q       <= bus.mem_pc_i;
                cause_q     <= exc_cause;
            end
            pend_q    <= pend_d;
            pend_pc_q <= pend_pc_d;
            flush_q   <= flush_d;
            rv_q      <= rv_d;
            rpc_q     <= rpc_d;
            tt_q      <= tt_d;
            tepc_q    <= tepc_d;
            tcause_q  <= tcause_d;
        end
    end

    assign bus.stall_o          = n_rst_i ? stall : 6'b000000;
    assign bus.flush_o          = flush_q;
    assign bus.redirect_valid_o = rv_q;
    assign bus.redirect_pc_o    = rpc_q;
    assign bus.trap_taken_o     = tt_q;
    assign bus.trap_epc_o       = tepc_q;
    assign bus.trap_cause_o     = tcause_q;
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - directed and randomized checks of pipe_ctrl against a behavioural model
module tb_pipe_ctrl;
    localparam logic [31:0] RESET_PC = 32'h0000_1000;

    logic clk_i = 1'b0;
    logic n_rst_i = 1'b0;
    int   total = 0;
    int   bad = 0;

    pipe_ctrl_if bus();

    pipe_ctrl #(.RESET_PC(RESET_PC)) dut (
        .clk_i  (clk_i),
        .n_rst_i(n_rst_i),
        .bus    (bus)
    );

    always #5 clk_i = ~clk_i;

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_inputs();
        bus.stallreq_if_i   = 1'b0;
        bus.stallreq_id_i   = 1'b0;
        bus.stallreq_ex_i   = 1'b0;
        bus.stallreq_mem_i  = 1'b0;
        bus.lsu_busy_i      = 1'b0;
        bus.exception_i     = '0;
        bus.mret_i          = 1'b0;
        bus.mem_pc_i        = '0;
        bus.mtvec_i         = '0;
        bus.mepc_i          = '0;
        bus.branch_i        = 1'b0;
        bus.branch_target_i = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        bus.stallreq_mem_i = 1'b1;
        n_rst_i = 1'b0;
        step();
        step();
        total++; if (bus.stall_o !== 6'h00) begin bad++; $display("FAIL rst_stall act=%h exp=00", bus.stall_o); end
        total++; if (bus.flush_o !== 1'b0) begin bad++; $display("FAIL rst_flush act=%b exp=0", bus.flush_o); end
        total++; if (bus.trap_taken_o !== 1'b0) begin bad++; $display("FAIL rst_tt act=%b exp=0", bus.trap_taken_o); end
        total++; if (bus.trap_epc_o !== 32'h0) begin bad++; $display("FAIL rst_epc act=%h exp=0", bus.trap_epc_o); end
        total++; if (bus.trap_cause_o !== 5'h0) begin bad++; $display("FAIL rst_cause act=%h exp=0", bus.trap_cause_o); end
        bus.stallreq_mem_i = 1'b0;
        n_rst_i = 1'b1;
        #1;
        total++; if (bus.redirect_valid_o !== 1'b1) begin bad++; $display("FAIL rst_rv act=%b exp=1", bus.redirect_valid_o); end
        total++; if (bus.redirect_pc_o !== RESET_PC) begin bad++; $display("FAIL rst_rpc act=%h exp=%h", bus.redirect_pc_o, RESET_PC); end
        step();
        total++; if (bus.redirect_valid_o !== 1'b0) begin bad++; $display("FAIL rst_rv_drop act=%b exp=0", bus.redirect_valid_o); end
    endtask

    task automatic test_priority();
        idle_inputs();
        bus.stallreq_if_i = 1'b1;
        bus.stallreq_ex_i = 1'b1;
        #1;
        total++; if (bus.stall_o !== 6'b001111) begin bad++; $display("FAIL prio_if_ex act=%b exp=001111", bus.stall_o); end
        bus.stallreq_mem_i = 1'b1;
        #1;
        total++; if (bus.stall_o !== 6'b011111) begin bad++; $display("FAIL prio_mem act=%b exp=011111", bus.stall_o); end
        idle_inputs();
        #1;
        total++; if (bus.stall_o !== 6'b000000) begin bad++; $display("FAIL prio_none act=%b exp=000000", bus.stall_o); end
        bus.stallreq_id_i = 1'b1;
        bus.stallreq_if_i = 1'b1;
        #1;
        total++; if (bus.stall_o !== 6'b000111) begin bad++; $display("FAIL prio_id act=%b exp=000111", bus.stall_o); end
        bus.stallreq_id_i = 1'b0;
        #1;
        total++; if (bus.stall_o !== 6'b000011) begin bad++; $display("FAIL prio_if act=%b exp=000011", bus.stall_o); end
        idle_inputs();
        step();
    endtask

    task automatic test_trap_nodrain();
        idle_inputs();
        bus.exception_i = 32'h4;
        bus.mem_pc_i    = 32'h80;
        bus.mtvec_i     = 32'h101;
        #1;
        total++; if (bus.stall_o !== 6'h3F) begin bad++; $display("FAIL trap_stall act=%h exp=3f", bus.stall_o); end
        step();
        bus.exception_i = '0;
        #1;
        total++; if (bus.flush_o !== 1'b1) begin bad++; $display("FAIL trap_flush act=%b exp=1", bus.flush_o); end
        total++; if (bus.stall_o !== 6'h00) begin bad++; $display("FAIL trap_flush_stall act=%h exp=00", bus.stall_o); end
        total++; if (bus.redirect_valid_o !== 1'b1) begin bad++; $display("FAIL trap_rv act=%b exp=1", bus.redirect_valid_o); end
        total++; if (bus.redirect_pc_o !== 32'h100) begin bad++; $display("FAIL trap_rpc act=%h exp=100", bus.redirect_pc_o); end
        total++; if (bus.trap_taken_o !== 1'b1) begin bad++; $display("FAIL trap_tt act=%b exp=1", bus.trap_taken_o); end
        total++; if (bus.trap_epc_o !== 32'h80) begin bad++; $display("FAIL trap_epc act=%h exp=80", bus.trap_epc_o); end
        total++; if (bus.trap_cause_o !== 5'd2) begin bad++; $display("FAIL trap_cause act=%0d exp=2", bus.trap_cause_o); end
        step();
        total++; if ({bus.flush_o, bus.redirect_valid_o, bus.trap_taken_o} !== 3'b000) begin
            bad++; $display("FAIL trap_after act=%b exp=000", {bus.flush_o, bus.redirect_valid_o, bus.trap_taken_o});
        end
    endtask

    task automatic test_trap_drain();
        int stall_cycles = 0;
        idle_inputs();
        bus.mem_pc_i = 32'h1234;
        bus.mtvec_i  = 32'h2002;
        for (int c = 0; c < 4; c++) begin
            bus.exception_i = (c == 0) ? 32'h8 : 32'h0;
            bus.lsu_busy_i  = (c < 3);
            #1;
            if (bus.stall_o === 6'h3F) stall_cycles++;
            total++; if (bus.flush_o !== 1'b0) begin bad++; $display("FAIL drain_early_flush c=%0d act=%b exp=0", c, bus.flush_o); end
            step();
        end
        total++; if (stall_cycles != 4) begin bad++; $display("FAIL drain_stall_cycles act=%0d exp=4", stall_cycles); end
        total++; if (bus.flush_o !== 1'b1) begin bad++; $display("FAIL drain_flush act=%b exp=1", bus.flush_o); end
        total++; if (bus.redirect_pc_o !== 32'h2000) begin bad++; $display("FAIL drain_rpc act=%h exp=2000", bus.redirect_pc_o); end
        total++; if (bus.trap_cause_o !== 5'd3) begin bad++; $display("FAIL drain_cause act=%0d exp=3", bus.trap_cause_o); end
        total++; if (bus.trap_epc_o !== 32'h1234) begin bad++; $display("FAIL drain_epc act=%h exp=1234", bus.trap_epc_o); end
        step();
        total++; if (bus.flush_o !== 1'b0) begin bad++; $display("FAIL drain_after act=%b exp=0", bus.flush_o); end
    endtask

    task automatic test_mret();
        idle_inputs();
        bus.mret_i  = 1'b1;
        bus.mepc_i  = 32'h200;
        bus.mtvec_i = 32'h400;
        #1;
        total++; if (bus.stall_o !== 6'h3F) begin bad++; $display("FAIL mret_stall act=%h exp=3f", bus.stall_o); end
        step();
        bus.mret_i = 1'b0;
        #1;
        total++; if (bus.flush_o !== 1'b1) begin bad++; $display("FAIL mret_flush act=%b exp=1", bus.flush_o); end
        total++; if (bus.redirect_valid_o !== 1'b1) begin bad++; $display("FAIL mret_rv act=%b exp=1", bus.redirect_valid_o); end
        total++; if (bus.redirect_pc_o !== 32'h200) begin bad++; $display("FAIL mret_rpc act=%h exp=200", bus.redirect_pc_o); end
        total++; if (bus.trap_taken_o !== 1'b0) begin bad++; $display("FAIL mret_tt act=%b exp=0", bus.trap_taken_o); end
        step();
    endtask

    task automatic test_branch_stall();
        int rv_count = 0;
        idle_inputs();
        bus.stallreq_mem_i  = 1'b1;
        bus.branch_i        = 1'b1;
        bus.branch_target_i = 32'h44;
        #1;
        total++; if (bus.stall_o !== 6'b011111) begin bad++; $display("FAIL br_stall act=%b exp=011111", bus.stall_o); end
        step();
        bus.branch_i        = 1'b0;
        bus.branch_target_i = 32'h99;
        total++; if (bus.redirect_valid_o !== 1'b0) begin bad++; $display("FAIL br_held1 act=%b exp=0", bus.redirect_valid_o); end
        step();
        total++; if (bus.redirect_valid_o !== 1'b0) begin bad++; $display("FAIL br_held2 act=%b exp=0", bus.redirect_valid_o); end
        bus.stallreq_mem_i = 1'b0;
        step();
        total++; if (bus.redirect_valid_o !== 1'b1) begin bad++; $display("FAIL br_issue act=%b exp=1", bus.redirect_valid_o); end
        total++; if (bus.redirect_pc_o !== 32'h44) begin bad++; $display("FAIL br_target act=%h exp=44", bus.redirect_pc_o); end
        for (int c = 0; c < 3; c++) begin
            step();
            if (bus.redirect_valid_o === 1'b1) rv_count++;
        end
        total++; if (rv_count != 0) begin bad++; $display("FAIL br_once extra=%0d exp=0", rv_count); end
    endtask

    task automatic test_reset_mid_drain();
        int flushes = 0;
        idle_inputs();
        bus.exception_i = 32'h1;
        bus.lsu_busy_i  = 1'b1;
        bus.mtvec_i     = 32'h800;
        step();
        bus.exception_i = '0;
        step();
        n_rst_i = 1'b0;
        #1;
        total++; if (bus.stall_o !== 6'h00) begin bad++; $display("FAIL mid_rst_stall act=%h exp=00", bus.stall_o); end
        step();
        n_rst_i = 1'b1;
        bus.lsu_busy_i = 1'b0;
        #1;
        total++; if (bus.redirect_valid_o !== 1'b1) begin bad++; $display("FAIL mid_rst_rv act=%b exp=1", bus.redirect_valid_o); end
        total++; if (bus.redirect_pc_o !== RESET_PC) begin bad++; $display("FAIL mid_rst_rpc act=%h exp=%h", bus.redirect_pc_o, RESET_PC); end
        if (bus.flush_o === 1'b1) flushes++;
        for (int c = 0; c < 4; c++) begin
            step();
            if (bus.flush_o === 1'b1) flushes++;
        end
        total++; if (flushes != 0) begin bad++; $display("FAIL mid_rst_flush count=%0d exp=0", flushes); end
        total++; if (bus.stall_o !== 6'h00) begin bad++; $display("FAIL mid_rst_idle act=%h exp=00", bus.stall_o); end
    endtask

    task automatic test_random();
        int          mode = 0;       // 0 running, 1 waiting for lsu, 2 flushing
        int          next_mode;
        int          depth;
        bit          t_mret = 1'b0;
        logic [31:0] t_pc = '0;
        logic [4:0]  t_cause = '0;
        bit          pend = 1'b0;
        logic [31:0] pend_pc = '0;
        logic [5:0]  exp_stall;
        bit          go_flush, e_flush, e_rv, e_tt;
        logic [31:0] e_rpc = '0;
        idle_inputs();
        bus.mtvec_i = $urandom;
        bus.mepc_i  = $urandom;
        repeat (400) begin
            bus.stallreq_if_i   = ($urandom_range(3) == 0);
            bus.stallreq_id_i   = ($urandom_range(3) == 0);
            bus.stallreq_ex_i   = ($urandom_range(4) == 0);
            bus.stallreq_mem_i  = ($urandom_range(4) == 0);
            bus.lsu_busy_i      = ($urandom_range(4) < 2);
            bus.exception_i     = ($urandom_range(9) == 0) ? (($urandom | 32'h1) << $urandom_range(31)) : 32'h0;
            bus.mret_i          = ($urandom_range(9) == 0);
            bus.mem_pc_i        = $urandom;
            bus.branch_i        = ($urandom_range(2) == 0);
            bus.branch_target_i = $urandom;

            go_flush  = 1'b0;
            next_mode = mode;
            if (mode == 0 && (bus.exception_i != 0 || bus.mret_i)) begin
                exp_stall = 6'h3F;
                t_mret    = (bus.exception_i == 0);
                t_pc      = bus.mem_pc_i;
                for (int b = 0; b < 32; b++) begin
                    if (bus.exception_i[b]) begin t_cause = 5'(b); break; end
                end
                if (bus.lsu_busy_i) next_mode = 1;
                else go_flush = 1'b1;
            end else if (mode == 0) begin
                depth = bus.stallreq_mem_i ? 5 : bus.stallreq_ex_i ? 4 :
                        bus.stallreq_id_i ? 3 : bus.stallreq_if_i ? 2 : 0;
                exp_stall = 6'((1 << depth) - 1);
            end else if (mode == 1) begin
                exp_stall = 6'h3F;
                go_flush  = !bus.lsu_busy_i;
            end else begin
                exp_stall = 6'h00;
            end
            #1;
            total++; if (bus.stall_o !== exp_stall) begin bad++; $display("FAIL rnd_stall act=%h exp=%h", bus.stall_o, exp_stall); end

            e_flush = 1'b0; e_rv = 1'b0; e_tt = 1'b0;
            if (go_flush) begin
                e_flush = 1'b1; e_rv = 1'b1; e_tt = !t_mret;
                e_rpc = t_mret ? bus.mepc_i : {bus.mtvec_i[31:2], 2'b00};
                pend = 1'b0;
                next_mode = 2;
            end else if (mode == 2) begin
                next_mode = 0;
            end else if (!exp_stall[3] && pend) begin
                e_rv = 1'b1; e_rpc = pend_pc; pend = 1'b0;
            end else if (!exp_stall[3] && bus.branch_i) begin
                e_rv = 1'b1; e_rpc = bus.branch_target_i;
            end else if (exp_stall[3] && bus.branch_i && !pend) begin
                pend = 1'b1; pend_pc = bus.branch_target_i;
            end
            mode = next_mode;
            step();
            total++; if (bus.flush_o !== e_flush) begin bad++; $display("FAIL rnd_flush act=%b exp=%b", bus.flush_o, e_flush); end
            total++; if (bus.redirect_valid_o !== e_rv) begin bad++; $display("FAIL rnd_rv act=%b exp=%b", bus.redirect_valid_o, e_rv); end
            total++; if (bus.trap_taken_o !== e_tt) begin bad++; $display("FAIL rnd_tt act=%b exp=%b", bus.trap_taken_o, e_tt); end
            if (e_rv) begin
                total++; if (bus.redirect_pc_o !== e_rpc) begin bad++; $display("FAIL rnd_rpc act=%h exp=%h", bus.redirect_pc_o, e_rpc); end
            end
            if (e_tt) begin
                total++; if (bus.trap_epc_o !== t_pc) begin bad++; $display("FAIL rnd_epc act=%h exp=%h", bus.trap_epc_o, t_pc); end
                total++; if (bus.trap_cause_o !== t_cause) begin bad++; $display("FAIL rnd_cause act=%0d exp=%0d", bus.trap_cause_o, t_cause); end
            end
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_priority();
        test_trap_nodrain();
        test_trap_drain();
        test_mret();
        test_branch_stall();
        test_reset_mid_drain();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
